// File: rtl/preset_timer.sv
// Programmable preset timer: up/down counting, one-shot or auto-reload, pause/resume,
// and a single-cycle terminal-count pulse.
module preset_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir_up,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] start_val_c;
  logic [WIDTH-1:0] term_val_c;
  logic [WIDTH-1:0] step_val_c;
  logic             at_term_c;
  logic             step_hits_term_c;
  logic             zero_period_c;

  // Period endpoints swap roles with direction; the reload register is always the far end.
  always_comb begin
    start_val_c      = dir_q ? '0 : reload_q;
    term_val_c       = dir_q ? reload_q : '0;
    step_val_c       = dir_q ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
    at_term_c        = (count_q == term_val_c);
    step_hits_term_c = (step_val_c == term_val_c);
    zero_period_c    = (start_val_c == term_val_c);
  end

  // Next-state: load > stop > start > counting; rst is applied in the register block.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    dir_d    = dir_q;
    tc_d     = 1'b0;

    if (load) begin
      reload_d = load_val;
      dir_d    = dir_up;
      count_d  = dir_up ? '0 : load_val;
      state_d  = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count_d = start_val_c;
            if (zero_period_c) begin
              state_d = ST_DONE;
              tc_d    = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_HOLD: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_HOLD;
          end else if (!at_term_c) begin
            count_d = step_val_c;
            if (step_hits_term_c) begin
              tc_d = 1'b1;
              if (!auto_reload) begin
                state_d = ST_DONE;
              end
            end
          end else begin
            // Sitting on terminal only happens in auto-reload: begin the next period.
            count_d = start_val_c;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      dir_q    <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      dir_q    <= dir_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_preset_timer.sv
// Bench for preset_timer (WIDTH=4): directed vector table, hand sequences and
// randomized traffic checked against a position-in-period reference model.
module tb_preset_timer;

  localparam int unsigned W = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst, load, dir_up, start, stop, auto_reload;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         tc, busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model: progress through the period rather than the count itself.
  int m_pos, m_reload, m_mode;
  bit m_dir, m_tc;

  typedef struct {
    logic         rst, load;
    logic [W-1:0] lv;
    logic         du, start, stop, ar;
    logic [W-1:0] ec;
    logic         etc, eb, ed;
  } vec_t;

  vec_t vecs[17];

  preset_timer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load(load), .load_val(load_val), .dir_up(dir_up),
    .start(start), .stop(stop), .auto_reload(auto_reload),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic ld, input int lv, input logic du,
                              input logic st, input logic sp, input logic ar,
                              input int ec, input logic etc, input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.load = ld; v.lv = W'(lv); v.du = du; v.start = st; v.stop = sp; v.ar = ar;
    v.ec = W'(ec); v.etc = etc; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  function automatic int m_count();
    return m_dir ? m_pos : (m_reload - m_pos);
  endfunction

  task automatic model_step();
    m_tc = 1'b0;
    if (rst) begin
      m_pos = 0; m_reload = 0; m_dir = 1'b0; m_mode = M_IDLE;
    end else if (load) begin
      m_reload = int'(load_val); m_dir = dir_up; m_pos = 0; m_mode = M_IDLE;
    end else if (stop && m_mode == M_RUN) begin
      m_mode = M_HOLD;
    end else if (start && (m_mode == M_IDLE || m_mode == M_DONE)) begin
      m_pos = 0;
      if (m_reload == 0) begin
        m_mode = M_DONE; m_tc = 1'b1;
      end else begin
        m_mode = M_RUN;
      end
    end else if (start && m_mode == M_HOLD) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (m_pos < m_reload) begin
        m_pos++;
        if (m_pos == m_reload) begin
          m_tc = 1'b1;
          if (!auto_reload) m_mode = M_DONE;
        end
      end else begin
        m_pos = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic ld, input int lv, input logic du,
                        input logic st, input logic sp, input logic ar);
    rst = r; load = ld; load_val = W'(lv); dir_up = du; start = st; stop = sp; auto_reload = ar;
  endtask

  // One clock edge, then sample away from it and advance the model.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, int'(count), m_count());
    chk({tag, ".tc"}, int'(tc), int'(m_tc));
    chk({tag, ".busy"}, int'(busy), int'(m_mode == M_RUN));
    chk({tag, ".done"}, int'(done), int'(m_mode == M_DONE));
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_model(tag);
    end
  endtask

  initial begin
    int tcs;
    int guard;
    logic ar_r;

    set_in(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_pos = 0; m_reload = 0; m_dir = 1'b0; m_mode = M_IDLE; m_tc = 1'b0;

    // Reset with noisy inputs, one-shot down from 5, restart from DONE, zero-period starts.
    vecs[0]  = mk(1, 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 0, 0, 0, 0);
    vecs[1]  = mk(1, 1'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 5, 0, 0, 0, 0,  5, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 1, 0, 0,  5, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0,  4, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0,  3, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0,  2, 0, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 1, 0, 1,  5, 0, 1, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 0, 1,  0, 1, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1);
    vecs[15] = mk(0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 1, 0, 0,  0, 1, 0, 1);

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].rst, vecs[i].load, int'(vecs[i].lv), vecs[i].du,
             vecs[i].start, vecs[i].stop, vecs[i].ar);
      tick();
      chk($sformatf("vec%0d.count", i), int'(count), int'(vecs[i].ec));
      chk($sformatf("vec%0d.tc", i), int'(tc), int'(vecs[i].etc));
      chk($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].eb));
      chk($sformatf("vec%0d.done", i), int'(done), int'(vecs[i].ed));
    end

    // Auto-reload down from 3: tc every 4th cycle, then drop auto_reload at count 2.
    set_in(0, 1, 3, 0, 0, 0, 1); run(1, "ar_load");
    set_in(0, 0, 0, 0, 1, 0, 1); run(1, "ar_start");
    set_in(0, 0, 0, 0, 0, 0, 1);
    tcs = 0;
    for (int i = 0; i < 12; i++) begin
      tick(); check_model("ar_run");
      if (tc) tcs++;
    end
    chk("ar_tc_pulses", tcs, 3);
    guard = 0;
    while (count != W'(2) && guard < 10) begin
      tick(); check_model("ar_seek"); guard++;
    end
    chk("ar_seek_reached", int'(count), 2);
    set_in(0, 0, 0, 0, 0, 0, 0);
    guard = 0;
    while (!done && guard < 8) begin
      tick(); check_model("ar_drain"); guard++;
    end
    chk("ar_drain_cycles", guard, 2);
    chk("ar_drain_count", int'(count), 0);

    // Up mode over the full 4-bit range.
    set_in(0, 1, 15, 1, 0, 0, 0); run(1, "up_load");
    set_in(0, 0, 0, 0, 1, 0, 0); run(1, "up_start");
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      tick(); check_model("up_run");
      chk("up_count", int'(count), i);
      chk("up_tc", int'(tc), int'(i == 15));
    end
    run(2, "up_done");
    chk("up_hold_count", int'(count), 15);

    // Pause and resume, load mid-run, stop+start together.
    set_in(0, 1, 6, 0, 0, 0, 0); run(1, "p_load");
    set_in(0, 0, 0, 0, 1, 0, 0); run(1, "p_start");
    set_in(0, 0, 0, 0, 0, 0, 0); run(3, "p_run");
    set_in(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); check_model("p_hold");
      chk("p_frozen", int'(count), 3);
      chk("p_busy", int'(busy), 0);
    end
    set_in(0, 0, 0, 0, 1, 0, 0); run(1, "p_resume");
    set_in(0, 0, 0, 0, 0, 0, 0); run(3, "p_finish");
    chk("p_end_done", int'(done), 1);
    set_in(0, 1, 6, 0, 0, 0, 0); run(1, "l_load");
    set_in(0, 0, 0, 0, 1, 0, 0); run(1, "l_start");
    set_in(0, 0, 0, 0, 0, 0, 0); run(2, "l_run");
    set_in(0, 1, 9, 0, 0, 0, 0); run(1, "l_reload");
    chk("l_reload_count", int'(count), 9);
    chk("l_reload_tc", int'(tc), 0);
    set_in(0, 0, 0, 0, 1, 0, 0); run(2, "ss_run");
    set_in(0, 0, 0, 0, 1, 1, 0); run(1, "ss_both");
    chk("ss_hold_busy", int'(busy), 0);
    chk("ss_hold_count", int'(count), 8);

    // Reset in the middle of a run.
    set_in(0, 1, 8, 0, 0, 0, 0); run(1, "r_load");
    set_in(0, 0, 0, 0, 1, 0, 0); run(1, "r_start");
    set_in(0, 0, 0, 0, 0, 0, 0); run(4, "r_run");
    chk("r_at_four", int'(count), 4);
    set_in(1, 0, 0, 0, 0, 0, 0); run(1, "r_reset");
    chk("r_count", int'(count), 0);
    chk("r_busy", int'(busy), 0);
    set_in(0, 0, 0, 0, 1, 0, 0); run(1, "r_zero_start");

    // Randomized traffic against the model.
    ar_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      int lv;
      r = int'($urandom_range(0, 9));
      lv = (r < 2) ? 0 : (r < 4) ? 15 : int'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) ar_r = ~ar_r;
      set_in(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 24) == 0), lv,
             1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0), ar_r);
      tick();
      check_model("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/preset_timer.md
Name: preset_timer

Overview:
Parametrised programmable timer that generalises the preset down-counter: configurable width, up or down direction, one-shot or auto-reload operation, pause/resume, and a one-cycle terminal-count pulse. It is a timing primitive for peripheral blocks (baud dividers, timeouts, periodic ticks). A controller drives it from register writes.

Parameters:
WIDTH, 8, width of count, load value and internal reload register.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
load  input  1  latch load_val/dir_up into reload register; reinitialise count; go IDLE.
load_val  input  WIDTH  preset value (down: start value; up: terminal value).
dir_up  input  1  direction, sampled only on load (1 = count up, 0 = count down).
start  input  1  start from IDLE/DONE, resume from HOLD.
stop  input  1  pause while RUN.
auto_reload  input  1  sampled live; 1 = reload and continue at terminal, 0 = one-shot.
count  output  WIDTH  current count value (registered).
tc  output  1  registered pulse; high exactly in the cycle count holds terminal value after a RUN step (or immediate start, below).
busy  output  1  state == RUN.
done  output  1  state == DONE.

Behaviour:
- Reset (rst=1 at edge, overrides all): count=0, reload_reg=0, dir_reg=0 (down), state=IDLE, tc=0, so busy=0, done=0.
- Definitions: start_val = dir_reg ? 0 : reload_reg; term_val = dir_reg ? reload_reg : 0.
- Priority per edge: rst > load > stop > start > counting.
- States: IDLE, RUN, HOLD, DONE. busy/done are combinational decodes of the registered state.
- load (any state): reload_reg<=load_val, dir_reg<=dir_up, count<=(dir_up ? 0 : load_val), state<=IDLE, tc<=0.
- start in IDLE or DONE: count<=start_val.
  - If start_val == term_val (e.g. down with reload 0, or up with reload 0): state<=DONE, tc<=1 next cycle. Applies even if auto_reload=1; no counting occurs.
  - Otherwise: state<=RUN.
- start in HOLD: state<=RUN; count unchanged.
- start in RUN: ignored.
- stop in RUN: state<=HOLD, count frozen. stop in other states: ignored. stop and start together: stop wins.
- RUN, count != term_val: count <= count±1 (+1 if dir_reg). Arithmetic is modulo 2^WIDTH but never wraps in practice, because term_val is reached first. If the step lands on term_val: tc<=1, and state<=DONE if auto_reload=0, else stay RUN.
- RUN, count == term_val (only reachable with auto_reload=1): count<=start_val, tc<=0. Period = reload_reg+1 cycles; tc fires once per period.
- If auto_reload drops to 0 while count is mid-period: the timer finishes the current period and stops in DONE.
- DONE: count holds term_val; tc is high only in the first cycle.
- tc is 0 in every cycle not listed above.
- Mid-operation reset or load: abandon immediately with the values above; no tc is generated.
- WIDTH edge: load_val = 2^WIDTH-1 must count the full range in both directions.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> count=0, tc=0, busy=0, done=0.
- One-shot down: load 5 (dir_up=0), start, auto_reload=0 -> count 5,4,3,2,1,0; tc high only on the 0 cycle; done=1; count stays 0.
- Auto-reload down: load 3, auto_reload=1, start -> 3,2,1,0,3,2,1,0,...; tc every 4th cycle. Drop auto_reload at count=2 -> stops at 0 with done=1.
- Up mode at WIDTH=4: load 15 with dir_up=1, start -> count 0..15 with no wrap; tc at 15; done.
- Pause/override: down from 6, stop at count=3 for 5 cycles -> count frozen at 3, busy=0; start -> continues 2,1,0. load 9 mid-run -> count=9, IDLE, no tc. stop+start same cycle in RUN -> HOLD.
- Corner cases:
  - load 0 then start -> DONE next cycle, tc=1 for one cycle.
  - rst asserted mid-run at count=4 -> all outputs return to reset values on the next edge.
